// File: rtl/markers_pkg.sv
// Shared marker constants, lookup function and lock-state encoding for the
// marker inserter and the receive-side marker synchroniser.
package markers_pkg;

  localparam int unsigned MARK_LEN          = 44;
  localparam int unsigned DEFAULT_DATA_BITS = 2816;

  localparam logic [30:0] M  = 31'b1111100110100100001010111011000;
  localparam logic [30:0] nM = ~M;
  localparam logic [12:0] B  = 13'b1111100110101;
  localparam logic [12:0] nB = ~B;

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } state_e;

  function automatic logic [MARK_LEN-1:0] mark(input logic [1:0] idx);
    case (idx)
      2'd0:    mark = {M,  B};
      2'd1:    mark = {nM, B};
      2'd2:    mark = {M,  nB};
      default: mark = {nM, nB};
    endcase
  endfunction

endpackage

// File: rtl/marker_match.sv
// Combinational detector: flags when the 44-bit window equals any of the
// four frame markers and reports which one.
module marker_match
  import markers_pkg::*;
(
  input  logic [MARK_LEN-1:0] win_i,
  output logic                hit_o,
  output logic [1:0]          hit_idx_o
);

  always_comb begin
    hit_o     = 1'b0;
    hit_idx_o = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (win_i == mark(2'(k))) begin
        hit_o     = 1'b1;
        hit_idx_o = 2'(k);
      end
    end
  end

endmodule

// File: rtl/markers_sync.sv
// Frame synchroniser: hunts for 44-bit markers in a strobed serial stream,
// acquires/holds lock with a flywheel, and forwards payload bits only.
module markers_sync
  import markers_pkg::*;
#(
  parameter int unsigned DATA_BITS = DEFAULT_DATA_BITS,
  parameter int unsigned CONFIRM   = 2,
  parameter int unsigned MISS_MAX  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       idat,
  input  logic       ival,
  output logic       odat,
  output logic       oval,
  output logic       ofirst,
  output logic [1:0] oidx,
  output logic       osync,
  output logic       oerr
);

  localparam logic [11:0] POS_LAST  = 12'(DATA_BITS + MARK_LEN - 1);
  localparam logic [11:0] POS_DATA  = 12'(DATA_BITS);
  localparam logic [7:0]  CONFIRM_C = 8'(CONFIRM);
  localparam logic [7:0]  MISS_C    = 8'(MISS_MAX);

  state_e              state_q;
  logic [MARK_LEN-1:0] sr_q;
  logic [MARK_LEN-1:0] win;
  logic [11:0]         pos_q;
  logic [7:0]          hits_q, hits_d;
  logic [7:0]          miss_q, miss_d;
  logic [1:0]          exp_q, idx_q;
  logic                odat_q, oval_q, ofirst_q, osync_q, oerr_q;
  logic                hit;
  logic [1:0]          hit_idx;
  logic                exp_ok, at_mark;

  // Comparisons see the window including the bit being accepted this cycle.
  assign win     = {sr_q[MARK_LEN-2:0], idat};
  assign hits_d  = hits_q + 8'd1;
  assign miss_d  = miss_q + 8'd1;
  assign exp_ok  = (win == mark(exp_q));
  assign at_mark = (pos_q == POS_LAST);

  marker_match u_match (
    .win_i     (win),
    .hit_o     (hit),
    .hit_idx_o (hit_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= SEARCH;
      sr_q     <= '0;
      pos_q    <= '0;
      hits_q   <= '0;
      miss_q   <= '0;
      exp_q    <= '0;
      idx_q    <= '0;
      odat_q   <= 1'b0;
      oval_q   <= 1'b0;
      ofirst_q <= 1'b0;
      osync_q  <= 1'b0;
      oerr_q   <= 1'b0;
    end else begin
      oval_q   <= 1'b0;
      ofirst_q <= 1'b0;
      oerr_q   <= 1'b0;
      if (ival) begin
        sr_q <= win;
        case (state_q)
          SEARCH: begin
            if (hit) begin
              exp_q  <= hit_idx + 2'd1;
              idx_q  <= hit_idx;
              pos_q  <= '0;
              hits_q <= 8'd1;
              if (CONFIRM <= 1) begin
                state_q <= LOCKED;
                osync_q <= 1'b1;
              end else begin
                state_q <= VERIFY;
              end
            end
          end
          VERIFY: begin
            if (at_mark) begin
              if (exp_ok) begin
                hits_q <= hits_d;
                idx_q  <= exp_q;
                exp_q  <= exp_q + 2'd1;
                pos_q  <= '0;
                if (hits_d >= CONFIRM_C) begin
                  state_q <= LOCKED;
                  osync_q <= 1'b1;
                  miss_q  <= '0;
                end
              end else begin
                state_q <= SEARCH;
                hits_q  <= '0;
              end
            end else begin
              pos_q <= pos_q + 12'd1;
            end
          end
          LOCKED: begin
            if (pos_q < POS_DATA) begin
              odat_q   <= idat;
              oval_q   <= 1'b1;
              ofirst_q <= (pos_q == '0);
            end
            // Flywheel: the frame index advances whether or not the marker matched.
            if (at_mark) begin
              idx_q <= exp_q;
              exp_q <= exp_q + 2'd1;
              pos_q <= '0;
              if (exp_ok) begin
                miss_q <= '0;
              end else begin
                oerr_q <= 1'b1;
                if (miss_d >= MISS_C) begin
                  state_q <= SEARCH;
                  osync_q <= 1'b0;
                  hits_q  <= '0;
                  miss_q  <= '0;
                end else begin
                  miss_q <= miss_d;
                end
              end
            end else begin
              pos_q <= pos_q + 12'd1;
            end
          end
          default: state_q <= SEARCH;
        endcase
      end
    end
  end

  assign odat   = odat_q;
  assign oval   = oval_q;
  assign ofirst = ofirst_q;
  assign oidx   = idx_q;
  assign osync  = osync_q;
  assign oerr   = oerr_q;

endmodule

// File: tb/tb_markers_sync.sv
// Scoreboard bench for markers_sync: stimulus queues expected payload bits,
// a negedge monitor pops and compares on every oval strobe.
module tb_markers_sync;

  localparam int DB = 2816;

  logic       clk = 1'b0;
  logic       reset;
  logic       idat;
  logic       ival;
  logic       odat, oval, ofirst, osync, oerr;
  logic [1:0] oidx;

  always #5 clk = ~clk;

  markers_sync #(
    .DATA_BITS (DB),
    .CONFIRM   (2),
    .MISS_MAX  (2)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .idat   (idat),
    .ival   (ival),
    .odat   (odat),
    .oval   (oval),
    .ofirst (ofirst),
    .oidx   (oidx),
    .osync  (osync),
    .oerr   (oerr)
  );

  typedef struct packed {
    logic       d;
    logic       first;
    logic [1:0] idx;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   passed   = 0;
  int   oerr_cnt = 0;
  int   gap      = 0;
  int   base;

  localparam logic [30:0] TM = 31'b1111100110100100001010111011000;
  localparam logic [12:0] TB = 13'b1111100110101;
  localparam logic [43:0] BIT20 = 44'h000_0010_0000;

  function automatic logic [43:0] tmark(input int k);
    case (k % 4)
      0:       tmark = {TM, TB};
      1:       tmark = {~TM, TB};
      2:       tmark = {TM, ~TB};
      default: tmark = {~TM, ~TB};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (oerr === 1'b1) oerr_cnt++;
    if (oval === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_oval: got oval=1 at %0t required no strobe", $time);
      end else begin
        e = sb.pop_front();
        if ({odat, ofirst, oidx} === {e.d, e.first, e.idx}) passed++;
        else $display("FAIL payload: got d=%b first=%b idx=%0d required d=%b first=%b idx=%0d",
                      odat, ofirst, oidx, e.d, e.first, e.idx);
      end
    end
  end

  task automatic send_bit(input logic b);
    repeat (gap) begin @(posedge clk); #1; end
    ival = 1'b1;
    idat = b;
    @(posedge clk); #1;
    ival = 1'b0;
    idat = 1'b0;
  endtask

  task automatic send_marker(input int k, input logic [43:0] mask, input bit chk_pre);
    logic [43:0] w;
    w = tmark(k) ^ mask;
    for (int i = 43; i >= 0; i--) begin
      if (chk_pre && i == 0) chk("osync_before_last_marker_bit", osync, 0);
      send_bit(w[i]);
    end
  endtask

  task automatic send_payload(input int n, input bit fwd, input logic [1:0] idx, input int emb_off);
    logic [43:0] emb;
    logic        b;
    emb = tmark(1);
    for (int i = 0; i < n; i++) begin
      b = 1'($urandom_range(0, 1));
      if (emb_off >= 0 && i >= emb_off && i < emb_off + 44) b = emb[43 - (i - emb_off)];
      if (fwd) sb.push_back({b, logic'(i == 0), idx});
      send_bit(b);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_odat"},   odat,   0);
    chk({tag, "_oval"},   oval,   0);
    chk({tag, "_ofirst"}, ofirst, 0);
    chk({tag, "_oidx"},   oidx,   0);
    chk({tag, "_osync"},  osync,  0);
    chk({tag, "_oerr"},   oerr,   0);
  endtask

  task automatic reset_pulse(input string tag);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero(tag);
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    ival  = 1'b0;
    idat  = 1'b0;
    #1;
    reset_pulse("reset");

    // 1: clean stream from marker0, one bit every third cycle
    gap = 2;
    send_marker(0, '0, 0);
    send_payload(DB, 0, 2'd0, -1);
    chk("t1_osync_after_frame0", osync, 0);
    send_marker(1, '0, 1);
    chk("t1_osync_rise", osync, 1);
    chk("t1_oidx", oidx, 1);
    send_payload(DB, 1, 2'd1, -1);
    send_marker(2, '0, 0);
    chk("t1_oerr_clean", oerr, 0);
    chk("t1_drained", sb.size(), 0);

    // 2: noise then stream starting at marker2, back-to-back bits
    gap = 0;
    reset_pulse("t2_reset");
    send_payload(137, 0, 2'd0, -1);
    send_marker(2, '0, 0);
    send_payload(DB, 0, 2'd0, -1);
    send_marker(3, '0, 1);
    chk("t2_osync_rise", osync, 1);
    chk("t2_oidx", oidx, 3);
    send_payload(DB, 1, 2'd3, -1);
    send_marker(0, '0, 0);
    chk("t2_oidx_wrap", oidx, 0);
    send_payload(DB, 1, 2'd0, -1);
    send_marker(1, '0, 0);

    // 3: corrupted markers while locked
    base = oerr_cnt;
    send_payload(DB, 1, 2'd1, -1);
    send_marker(2, BIT20, 0);
    chk("t3_oerr_single", oerr, 1);
    chk("t3_osync_hold", osync, 1);
    send_payload(DB, 1, 2'd2, -1);
    send_marker(3, '0, 0);
    chk("t3_oerr_clean", oerr, 0);
    send_payload(DB, 1, 2'd3, -1);
    send_marker(0, BIT20, 0);
    chk("t3_oerr_first_of_two", oerr, 1);
    chk("t3_osync_after_one", osync, 1);
    send_payload(DB, 1, 2'd0, -1);
    send_marker(1, BIT20, 0);
    chk("t3_oerr_second", oerr, 1);
    chk("t3_osync_drop", osync, 0);

    // 4: marker0 then skipped index marker2 must not lock
    send_payload(DB, 0, 2'd0, -1);
    chk("t3_oerr_count", oerr_cnt - base, 3);
    send_marker(0, '0, 0);
    chk("t4_osync_verify", osync, 0);
    send_payload(DB, 0, 2'd0, -1);
    send_marker(2, '0, 0);
    chk("t4_osync_skip", osync, 0);
    send_payload(DB, 0, 2'd0, -1);
    send_marker(3, '0, 0);
    send_payload(DB, 0, 2'd0, -1);
    send_marker(0, '0, 1);
    chk("t4_relock", osync, 1);
    chk("t4_oidx", oidx, 0);

    // 5: marker1 pattern embedded in locked payload
    base = oerr_cnt;
    send_payload(DB, 1, 2'd0, 500);
    send_marker(1, '0, 0);
    chk("t5_oerr_marker", oerr, 0);
    chk("t5_osync", osync, 1);
    chk("t5_oerr_count", oerr_cnt - base, 0);

    // 6: asynchronous reset at payload bit 1000, then relock
    send_payload(1000, 1, 2'd1, -1);
    @(negedge clk); #1;
    chk("t6_osync_pre", osync, 1);
    chk("t6_oval_pre", oval, 1);
    ival  = 1'b1;
    idat  = 1'b1;
    reset = 1'b0;
    #1;
    chk_zero("t6_async");
    ival = 1'b0;
    idat = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("t6_drained", sb.size(), 0);
    send_payload(DB - 1001, 0, 2'd0, -1);
    send_marker(2, '0, 0);
    chk("t6_osync_verify", osync, 0);
    send_payload(DB, 0, 2'd0, -1);
    send_marker(3, '0, 1);
    chk("t6_relock", osync, 1);
    chk("t6_oidx", oidx, 3);
    send_payload(200, 1, 2'd3, -1);
    repeat (4) @(posedge clk);
    #1;
    chk("final_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
